// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting controller: state encoding,
// field-select codes and default timing constants in tick_100hz units.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET_SEC  = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_SEC  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_HOUR = 2'd3;

    localparam int unsigned HOLD_DLY_DEF   = 50;
    localparam int unsigned REPEAT_PER_DEF = 10;
    localparam int unsigned BLINK_HALF_DEF = 25;
    localparam int unsigned TIMEOUT_DEF    = 1000;

    function automatic logic [1:0] sel_of(input state_e s);
        logic [1:0] r;
        r = SEL_NONE;
        case (s)
            ST_SET_SEC:  r = SEL_SEC;
            ST_SET_MIN:  r = SEL_MIN;
            ST_SET_HOUR: r = SEL_HOUR;
            default:     r = SEL_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold-delay / auto-repeat pulse request for btn_up.
// Repeat only runs after an edge accepted while enabled; disabling clears it.
module btn_repeat #(
    parameter int unsigned HOLD_DLY   = 50,
    parameter int unsigned REPEAT_PER = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic tick,
    input  logic btn,
    output logic pulse_c
);

    localparam int unsigned MAX_PER = (HOLD_DLY > REPEAT_PER) ? HOLD_DLY : REPEAT_PER;
    localparam int unsigned CW      = $clog2(MAX_PER) + 1;

    logic          btn_q;
    logic          active;
    logic          rep;
    logic [CW-1:0] cnt;
    logic          edge_c;
    logic          hit_c;

    assign edge_c  = btn && !btn_q;
    assign hit_c   = active && btn && tick &&
                     (rep ? (cnt >= CW'(REPEAT_PER - 1)) : (cnt >= CW'(HOLD_DLY - 1)));
    assign pulse_c = en && (edge_c || hit_c);

    // Ticks in the edge cycle are not counted so the hold delay starts after the press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q  <= 1'b0;
            active <= 1'b0;
            rep    <= 1'b0;
            cnt    <= '0;
        end else begin
            btn_q <= btn;
            if (!en || !btn) begin
                active <= 1'b0;
                rep    <= 1'b0;
                cnt    <= '0;
            end else if (edge_c) begin
                active <= 1'b1;
                rep    <= 1'b0;
                cnt    <= '0;
            end else if (hit_c) begin
                rep <= 1'b1;
                cnt <= '0;
            end else if (active && tick && (cnt != '1)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: field-select FSM, inactivity timeout, field blink,
// and routing of btn_up increment pulses to the selected field.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned HOLD_DLY   = HOLD_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF,
    parameter int unsigned BLINK_HALF = BLINK_HALF_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_mode,
    input  logic       tick_100hz,
    input  logic       btn_next,
    input  logic       btn_exit,
    input  logic       btn_up,
    output logic       o_h,
    output logic       o_m,
    output logic       o_s,
    output logic [1:0] sel,
    output logic       blink_on
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned BW = $clog2(BLINK_HALF) + 1;

    state_e        state;
    state_e        state_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_nxt;
    logic          blink_nxt;
    logic          set_st;
    logic          chg;
    logic          timeout_c;
    logic          rep_en;
    logic          pulse_c;

    assign set_st    = (state != ST_IDLE);
    assign timeout_c = set_st && tick_100hz && !btn_up && (tcnt >= TW'(TIMEOUT - 1));
    assign chg       = (state_nxt != state);
    assign rep_en    = set_st && !chg;

    btn_repeat #(
        .HOLD_DLY   (HOLD_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_btn_repeat (
        .clk     (clk),
        .reset   (reset),
        .en      (rep_en),
        .tick    (tick_100hz),
        .btn     (btn_up),
        .pulse_c (pulse_c)
    );

    // Next state: sw_mode low beats exit, which beats next, which beats timeout
    always_comb begin
        state_nxt = state;
        if (set_st) begin
            if (!sw_mode || btn_exit) begin
                state_nxt = ST_IDLE;
            end else if (btn_next) begin
                case (state)
                    ST_SET_HOUR: state_nxt = ST_SET_MIN;
                    ST_SET_MIN:  state_nxt = ST_SET_SEC;
                    default:     state_nxt = ST_IDLE;
                endcase
            end else if (timeout_c) begin
                state_nxt = ST_IDLE;
            end
        end else if (sw_mode && btn_next) begin
            state_nxt = ST_SET_HOUR;
        end
    end

    // Inactivity and blink counters
    always_comb begin
        tcnt_nxt = tcnt;
        if (!set_st || chg || btn_next || btn_exit || btn_up) begin
            tcnt_nxt = '0;
        end else if (tick_100hz && (tcnt != TW'(TIMEOUT))) begin
            tcnt_nxt = tcnt + TW'(1);
        end

        bcnt_nxt  = bcnt;
        blink_nxt = blink_on;
        if (state_nxt == ST_IDLE) begin
            bcnt_nxt  = '0;
            blink_nxt = 1'b0;
        end else if (chg || btn_up) begin
            bcnt_nxt  = '0;
            blink_nxt = 1'b1;
        end else if (tick_100hz) begin
            if (bcnt >= BW'(BLINK_HALF - 1)) begin
                bcnt_nxt  = '0;
                blink_nxt = !blink_on;
            end else begin
                bcnt_nxt = bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sel      <= SEL_NONE;
            tcnt     <= '0;
            bcnt     <= '0;
            blink_on <= 1'b0;
            o_h      <= 1'b0;
            o_m      <= 1'b0;
            o_s      <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_of(state_nxt);
            tcnt     <= tcnt_nxt;
            bcnt     <= bcnt_nxt;
            blink_on <= blink_nxt;
            o_h      <= pulse_c && (state == ST_SET_HOUR);
            o_m      <= pulse_c && (state == ST_SET_MIN);
            o_s      <= pulse_c && (state == ST_SET_SEC);
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: field stepping, hold/repeat timing,
// blink, timeout, sw_mode exit and asynchronous reset behaviour.
module tb_watch_set_ctrl;

    logic       clk;
    logic       reset;
    logic       sw_mode;
    logic       tick_100hz;
    logic       btn_next;
    logic       btn_exit;
    logic       btn_up;
    logic       o_h;
    logic       o_m;
    logic       o_s;
    logic [1:0] sel;
    logic       blink_on;

    int vectors;
    int errors;
    int cnt_h;
    int cnt_m;
    int cnt_s;

    watch_set_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sw_mode    (sw_mode),
        .tick_100hz (tick_100hz),
        .btn_next   (btn_next),
        .btn_exit   (btn_exit),
        .btn_up     (btn_up),
        .o_h        (o_h),
        .o_m        (o_m),
        .o_s        (o_s),
        .sel        (sel),
        .blink_on   (blink_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, tally pulses
    task automatic step();
        logic ok;
        @(posedge clk);
        #1;
        if (o_h === 1'b1) cnt_h++;
        if (o_m === 1'b1) cnt_m++;
        if (o_s === 1'b1) cnt_s++;
        ok = ($countones({o_h, o_m, o_s}) <= 1) && !((sel == 2'd0) && (o_h || o_m || o_s));
        chk("pulse_onehot_not_idle", 32'(ok), 32'd1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_100hz = 1'b1;
            step();
            tick_100hz = 1'b0;
            step();
        end
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
    endtask

    initial begin
        vectors = 0; errors = 0;
        cnt_h = 0; cnt_m = 0; cnt_s = 0;
        reset = 1'b0; sw_mode = 1'b0; tick_100hz = 1'b0;
        btn_next = 1'b0; btn_exit = 1'b0; btn_up = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_blink", 32'(blink_on), 32'd0);
        chk("rst_pulses", 32'({o_h, o_m, o_s}), 32'd0);
        reset = 1'b1;
        step();

        // Enter SET_HOUR, single tap of btn_up
        sw_mode = 1'b1;
        press_next();
        chk("enter_hour_sel", 32'(sel), 32'd3);
        chk("enter_hour_blink", 32'(blink_on), 32'd1);
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        chk("tap_o_h", 32'(o_h), 32'd1);
        chk("tap_o_m", 32'(o_m), 32'd0);
        chk("tap_o_s", 32'(o_s), 32'd0);
        step();
        chk("tap_o_h_width", 32'(o_h), 32'd0);

        // SET_MIN hold for 100 ticks: edge, then ticks 50,60,...,100
        press_next();
        chk("min_sel", 32'(sel), 32'd2);
        cnt_m = 0;
        btn_up = 1'b1;
        step();
        chk("hold_edge_o_m", 32'(o_m), 32'd1);
        for (int k = 1; k <= 100; k++) begin
            tick_100hz = 1'b1;
            step();
            tick_100hz = 1'b0;
            chk($sformatf("hold_tick%0d_o_m", k), 32'(o_m),
                32'((k >= 50) && (((k - 50) % 10) == 0)));
            step();
        end
        chk("hold_blink_forced", 32'(blink_on), 32'd1);
        btn_up = 1'b0;
        step();
        chk("hold_total_o_m", 32'(cnt_m), 32'd7);
        chk("hold_sel_kept", 32'(sel), 32'd2);

        // SET_SEC: btn_next with btn_up edge in the same cycle
        press_next();
        chk("sec_sel", 32'(sel), 32'd1);
        cnt_s = 0;
        btn_next = 1'b1;
        btn_up = 1'b1;
        step();
        btn_next = 1'b0;
        chk("sec_next_sel", 32'(sel), 32'd0);
        chk("sec_next_o_s", 32'(o_s), 32'd0);
        chk("sec_next_blink", 32'(blink_on), 32'd0);
        step();
        btn_up = 1'b0;
        step();
        chk("sec_no_o_s", 32'(cnt_s), 32'd0);

        // Blink toggles at ticks 25, 50, 75 in SET_HOUR
        press_next();
        chk("blink_start", 32'(blink_on), 32'd1);
        for (int k = 1; k <= 75; k++) begin
            tick_100hz = 1'b1;
            step();
            tick_100hz = 1'b0;
            chk($sformatf("blink_tick%0d", k), 32'(blink_on), 32'(((k / 25) % 2) == 0));
            step();
        end
        press_next();
        chk("field_change_sel", 32'(sel), 32'd2);
        chk("field_change_blink", 32'(blink_on), 32'd1);

        // btn_exit leaves setting
        btn_exit = 1'b1;
        step();
        btn_exit = 1'b0;
        chk("exit_sel", 32'(sel), 32'd0);

        // Timeout after 1000 idle ticks
        press_next();
        ticks(999);
        chk("timeout_999_sel", 32'(sel), 32'd3);
        ticks(1);
        chk("timeout_1000_sel", 32'(sel), 32'd0);
        chk("timeout_blink", 32'(blink_on), 32'd0);

        // btn_up at tick 999 restarts the inactivity count
        press_next();
        ticks(998);
        tick_100hz = 1'b1;
        btn_up = 1'b1;
        step();
        tick_100hz = 1'b0;
        btn_up = 1'b0;
        chk("restart_o_h", 32'(o_h), 32'd1);
        chk("restart_sel", 32'(sel), 32'd3);
        step();
        ticks(999);
        chk("restart_999_sel", 32'(sel), 32'd3);
        ticks(1);
        chk("restart_1000_sel", 32'(sel), 32'd0);

        // sw_mode drop during hold, on the tick that would repeat
        press_next();
        press_next();
        chk("mode_min_sel", 32'(sel), 32'd2);
        btn_up = 1'b1;
        step();
        chk("mode_edge_o_m", 32'(o_m), 32'd1);
        cnt_m = 0;
        ticks(49);
        chk("mode_pre_hold_o_m", 32'(cnt_m), 32'd0);
        tick_100hz = 1'b1;
        sw_mode = 1'b0;
        step();
        tick_100hz = 1'b0;
        chk("mode_drop_sel", 32'(sel), 32'd0);
        chk("mode_drop_o_m", 32'(o_m), 32'd0);
        ticks(20);
        chk("mode_after_o_m", 32'(cnt_m), 32'd0);
        sw_mode = 1'b1;
        btn_up = 1'b0;
        step();

        // Reset mid-hold clears outputs at once and needs a fresh press
        press_next();
        btn_up = 1'b1;
        step();
        chk("rst_hold_o_h", 32'(o_h), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_o_h", 32'(o_h), 32'd0);
        chk("rst_async_sel", 32'(sel), 32'd0);
        chk("rst_async_blink", 32'(blink_on), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        cnt_h = 0;
        press_next();
        chk("post_rst_sel", 32'(sel), 32'd3);
        ticks(60);
        chk("post_rst_no_o_h", 32'(cnt_h), 32'd0);
        btn_up = 1'b0;
        step();
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        chk("post_rst_repress_o_h", 32'(o_h), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 Parameter HOLD_DLY, 50, tick_100hz count of continuous btn_up hold before auto-repeat starts (0.5 s).
REQ-002 Parameter REPEAT_PER, 10, tick_100hz count between auto-repeat pulses (0.1 s).
REQ-003 Parameter BLINK_HALF, 25, tick_100hz count per blink half-period (2 Hz blink).
REQ-004 Parameter TIMEOUT, 1000, tick_100hz count of button inactivity before automatic exit (10 s).
REQ-005 Port clk  input  1  single system clock; all state on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port sw_mode  input  1  1 = watch mode selected; 0 forces exit from setting.
REQ-008 Port tick_100hz  input  1  one-clk pulse at 100 Hz from the watch datapath.
REQ-009 Port btn_next  input  1  debounced one-clk pulse; enter setting / advance field.
REQ-010 Port btn_exit  input  1  debounced one-clk pulse; leave setting.
REQ-011 Port btn_up  input  1  debounced level; increment selected field while high.
REQ-012 Port o_h, o_m, o_s  output  1 each  one-clk increment pulses to datapath i_h/i_m/i_s.
REQ-013 Port sel  output  2  selected field: 0 none, 1 sec, 2 min, 3 hour.
REQ-014 Port blink_on  output  1  display-enable for selected field; 1 = show digits.

Function
REQ-015 FSM states SHALL be IDLE, SET_HOUR, SET_MIN, SET_SEC; sel SHALL equal 0/3/2/1 respectively, registered.
REQ-016 IDLE -> SET_HOUR on btn_next while sw_mode=1; SET_HOUR -> SET_MIN -> SET_SEC -> IDLE on successive btn_next.
REQ-017 Any SET state -> IDLE on btn_exit, on sw_mode=0 (same cycle, highest priority), or on timeout.
REQ-018 Priority per cycle: sw_mode=0 > btn_exit > btn_next > timeout > btn_up activity.
REQ-019 btn_up rising edge sampled in a SET state at cycle N SHALL produce exactly one pulse on the selected field's output at cycle N+1.
REQ-020 While btn_up stays high, after HOLD_DLY tick_100hz pulses since the edge, one pulse SHALL issue, then one every REPEAT_PER ticks until btn_up falls.
REQ-021 Every pulse on o_h/o_m/o_s SHALL be exactly one clk wide; at most one of the three high per cycle; none in IDLE.
REQ-022 No increment pulse SHALL issue in a cycle where the state changes; hold/repeat counter clears on state change.
REQ-023 Timeout counter counts tick_100hz in SET states, clears on btn_next, btn_exit or btn_up high; reaching TIMEOUT forces IDLE.
REQ-024 blink_on SHALL toggle every BLINK_HALF ticks in SET states, be forced 1 while btn_up is high, restart at 1 on field change, and be 0 in IDLE.
REQ-025 Counter widths SHALL be $clog2 of their parameter + 1; counters saturate, never wrap.

Reset
REQ-026 reset=0 SHALL asynchronously force state IDLE, sel=0, o_h=o_m=o_s=0, blink_on=0, all counters and edge-detect register to 0.
REQ-027 Reset asserted mid-hold SHALL cancel repeat; after release, a still-high btn_up SHALL NOT pulse until it falls and rises again.

Structure
REQ-028 Shared package watch_pkg SHALL hold the state encoding, sel codes, and default HOLD_DLY/REPEAT_PER/BLINK_HALF/TIMEOUT constants.
REQ-029 One sub-module btn_repeat SHALL implement edge detect plus hold/repeat pulse generation; the FSM, timeout and blink stay in watch_set_ctrl.

Verification
REQ-030 Reset, sw_mode=1, btn_next x1 -> sel=3; btn_up 1-clk high -> single o_h pulse next cycle, o_m=o_s=0.
REQ-031 SET_MIN, btn_up held 100 ticks -> o_m pulses at edge+1 clk, tick 50, 60, 70, 80, 90, 100 (7 total).
REQ-032 SET_SEC, btn_next and btn_up edge same cycle -> state IDLE, sel=0, no o_s pulse.
REQ-033 SET_HOUR, no buttons 1000 ticks -> IDLE at tick 1000, blink_on=0; btn_up at tick 999 restarts count.
REQ-034 SET_MIN with btn_up held, sw_mode->0 -> IDLE same cycle, no further o_m; reset mid-hold -> all outputs 0 immediately.
REQ-035 SET_HOUR idle -> blink_on toggles at ticks 25, 50, 75; btn_next -> sel=2, blink_on=1.
